// File: rtl/sram_fifo_1w1r_if.sv
// ---------------------------------------------------------------------------
// sram_fifo_1w1r_if : push/pop handshake bundle for sram_fifo_1w1r  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface sram_fifo_1w1r_if #(
   parameter int WWORD = 32,
   parameter int DEPTH = 512,
   parameter int WLVL  = $clog2(DEPTH + 3)
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WWORD-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WWORD-1:0] out_data;
   logic [WLVL-1:0]  level;
   logic             afull;

   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, level, afull
   );

   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, level, afull
   );
endinterface

`default_nettype wire

// File: rtl/sram_fifo_1w1r.sv
// ---------------------------------------------------------------------------
// sram_fifo_1w1r : show-ahead FIFO on a 1W1R SRAM with 2-entry output skid
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bhv_1w1r_sram #(
   parameter int WWORD = 32,
   parameter int DEPTH = 512,
   parameter int WADDR = $clog2(DEPTH)
) (
   input  wire logic             clka,
   input  wire logic             cena,
   input  wire logic [WADDR-1:0] aa,
   output logic      [WWORD-1:0] qa,
   input  wire logic             clkb,
   input  wire logic             cenb,
   input  wire logic [WADDR-1:0] ab,
   input  wire logic [WWORD-1:0] db
);
   logic [WWORD-1:0] mem [DEPTH];

   always_ff @(posedge clka) begin
      if (!cena) qa <= mem[aa];
   end

   always_ff @(posedge clkb) begin
      if (!cenb) mem[ab] <= db;
   end
endmodule

module sram_fifo_1w1r #(
   parameter int WWORD    = 32,
   parameter int DEPTH    = 512,
   parameter int WADDR    = $clog2(DEPTH),
   parameter int WLVL     = $clog2(DEPTH + 3),
   parameter int AFULL_TH = DEPTH - 4
) (
   input  wire logic       clk,
   input  wire logic       rst,
   sram_fifo_1w1r_if.slave bus
);
   localparam int WCNT = $clog2(DEPTH + 1);

   logic [WADDR-1:0] r_wp, r_rp;
   logic [WCNT-1:0]  r_sram_cnt;
   logic             r_inflight;
   logic [1:0]       r_skid_cnt;
   logic [WWORD-1:0] r_skid [2];
   logic             r_head, r_tail;
   logic [WLVL-1:0]  r_level;
   logic             r_afull;

   logic             w_clr, w_push, w_pop, w_bypass, w_write, w_issue, w_enq;
   logic [2:0]       w_occ;
   logic [WWORD-1:0] w_qa, w_enq_data;
   logic [WLVL-1:0]  w_level_nxt;

   function automatic logic [WADDR-1:0] f_inc(input logic [WADDR-1:0] p);
      return (p == WADDR'(DEPTH - 1)) ? '0 : p + WADDR'(1);
   endfunction

   assign w_clr         = rst || bus.flush;
   assign bus.in_ready  = (r_sram_cnt != WCNT'(DEPTH));
   assign bus.out_valid = (r_skid_cnt != 2'd0);
   assign bus.out_data  = r_skid[r_head];
   assign bus.level     = r_level;
   assign bus.afull     = r_afull;

   assign w_push = bus.in_valid && bus.in_ready;
   assign w_pop  = bus.out_valid && bus.out_ready;

   // Bypass only when nothing older sits in the SRAM or the read pipe.
   assign w_bypass = (r_sram_cnt == '0) && !r_inflight && ((r_skid_cnt != 2'd2) || w_pop);
   assign w_write  = w_push && !w_bypass;

   // A read is issued only if a skid slot is guaranteed for its return.
   assign w_occ   = 3'(r_skid_cnt) + 3'(r_inflight) - 3'(w_pop);
   assign w_issue = (r_sram_cnt != '0) && (w_occ < 3'd2);

   // Bypass needs inflight==0, so at most one skid enqueue per cycle.
   assign w_enq      = (w_push && w_bypass) || r_inflight;
   assign w_enq_data = r_inflight ? w_qa : bus.in_data;

   assign w_level_nxt = r_level + WLVL'(w_push) - WLVL'(w_pop);

   bhv_1w1r_sram #(
      .WWORD (WWORD),
      .DEPTH (DEPTH),
      .WADDR (WADDR)
   ) u_sram (
      .clka (clk),
      .cena (!(w_issue && !w_clr)),
      .aa   (r_rp),
      .qa   (w_qa),
      .clkb (clk),
      .cenb (!(w_write && !w_clr)),
      .ab   (r_wp),
      .db   (bus.in_data)
   );

   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_sram_cnt <= '0;
         r_inflight <= 1'b0;
         r_skid_cnt <= 2'd0;
         r_head     <= 1'b0;
         r_tail     <= 1'b0;
         r_level    <= '0;
         r_afull    <= 1'b0;
      end else begin
         if (w_write) r_wp <= f_inc(r_wp);
         if (w_issue) r_rp <= f_inc(r_rp);
         r_sram_cnt <= r_sram_cnt + WCNT'(w_write) - WCNT'(w_issue);
         r_inflight <= w_issue;
         r_skid_cnt <= r_skid_cnt + 2'(w_enq) - 2'(w_pop);
         if (w_enq) r_tail <= ~r_tail;
         if (w_pop) r_head <= ~r_head;
         r_level    <= w_level_nxt;
         r_afull    <= (int'(w_level_nxt) >= AFULL_TH);
      end
   end

   always_ff @(posedge clk) begin
      if (w_enq) r_skid[r_tail] <= w_enq_data;
   end
endmodule

`default_nettype wire

// File: tb/tb_sram_fifo_1w1r.sv
// ---------------------------------------------------------------------------
// tb_sram_fifo_1w1r : scoreboard bench for DEPTH=8 and DEPTH=5 instances
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_fifo_1w1r;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_fifo_1w1r_if #(.WWORD(32), .DEPTH(8)) a_if ();
   sram_fifo_1w1r_if #(.WWORD(32), .DEPTH(5)) b_if ();

   sram_fifo_1w1r #(.WWORD(32), .DEPTH(8)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
   sram_fifo_1w1r #(.WWORD(32), .DEPTH(5)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic        stall_a = 1'b0, stall_b = 1'b0;
   logic [31:0] hold_a, hold_b;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive, sample handshakes mid-cycle, score, then check state.
   task automatic step(input logic va, input logic [31:0] da, input logic ra, input logic fa,
                       input logic vb, input logic [31:0] db, input logic rb);
      a_if.in_valid = va; a_if.in_data = da; a_if.out_ready = ra; a_if.flush = fa;
      b_if.in_valid = vb; b_if.in_data = db; b_if.out_ready = rb;
      @(negedge clk);
      if (stall_a) begin
         chk("a_stall_valid", a_if.out_valid, 1);
         chk("a_stall_data", a_if.out_data, hold_a);
      end
      if (fa) begin
         qa.delete();
         stall_a = 1'b0;
      end else begin
         if (a_if.out_valid && ra) begin
            chk("a_pop_nonempty", qa.size() != 0, 1);
            if (qa.size() != 0) chk("a_data", a_if.out_data, qa.pop_front());
         end
         if (va && a_if.in_ready) qa.push_back(da);
         stall_a = a_if.out_valid && !ra;
         hold_a  = a_if.out_data;
      end
      if (stall_b) begin
         chk("b_stall_valid", b_if.out_valid, 1);
         chk("b_stall_data", b_if.out_data, hold_b);
      end
      if (b_if.out_valid && rb) begin
         chk("b_pop_nonempty", qb.size() != 0, 1);
         if (qb.size() != 0) chk("b_data", b_if.out_data, qb.pop_front());
      end
      if (vb && b_if.in_ready) qb.push_back(db);
      stall_b = b_if.out_valid && !rb;
      hold_b  = b_if.out_data;
      @(posedge clk);
      #1;
      chk("a_level", a_if.level, qa.size());
      chk("a_afull", a_if.afull, qa.size() >= 4);
      chk("b_level", b_if.level, qb.size());
      chk("b_afull", b_if.afull, qb.size() >= 1);
   endtask

   task automatic drain_a(input string tag);
      for (int i = 0; i < 40 && qa.size() > 0; i++) step(0, 0, 1, 0, 0, 0, 0);
      chk(tag, qa.size(), 0);
   endtask

   initial begin
      logic seen;
      a_if.in_valid = 0; a_if.in_data = 0; a_if.out_ready = 0; a_if.flush = 0;
      b_if.in_valid = 0; b_if.in_data = 0; b_if.out_ready = 0; b_if.flush = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      chk("rst_a_level", a_if.level, 0);
      chk("rst_a_valid", a_if.out_valid, 0);
      chk("rst_a_ready", a_if.in_ready, 1);
      chk("rst_a_afull", a_if.afull, 0);
      chk("rst_b_valid", b_if.out_valid, 0);

      // single word through the bypass
      step(1, 32'hA5, 0, 0, 0, 0, 0);
      chk("t1_valid", a_if.out_valid, 1);
      chk("t1_data", a_if.out_data, 32'hA5);
      step(0, 0, 1, 0, 0, 0, 0);
      chk("t1_empty", a_if.out_valid, 0);

      // fill to capacity while stalled, then drain gap-free
      for (int i = 0; i < 12; i++) step(1, i, 0, 0, 0, 0, 0);
      chk("t2_accepted", qa.size(), 10);
      chk("t2_in_ready", a_if.in_ready, 0);
      seen = 1'b0;
      for (int i = 0; i < 30 && qa.size() > 0; i++) begin
         if (seen) chk("t2_no_gap", a_if.out_valid, 1);
         if (a_if.out_valid) seen = 1'b1;
         step(0, 0, 1, 0, 0, 0, 0);
      end
      chk("t2_drained", qa.size(), 0);

      // random traffic on the non power-of-two instance
      for (int i = 0; i < 200; i++)
         step(0, 0, 0, 0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 40 && qb.size() > 0; i++) step(0, 0, 0, 0, 0, 0, 1);
      chk("t3_drained", qb.size(), 0);

      // full-rate streaming
      for (int i = 0; i < 100; i++) begin
         if (i > 0) chk("t4_rate", a_if.out_valid, 1);
         step(1, 32'h1000 + i, 1, 0, 0, 0, 0);
      end
      drain_a("t4_drained");

      // toggling out_ready with SRAM reads in flight
      for (int i = 0; i < 6; i++) step(1, 32'h2000 + i, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) step(i[0], 32'h2100 + i, !i[0], 0, 0, 0, 0);
      drain_a("t5_drained");

      // flush with level 7 and a read in flight
      for (int i = 0; i < 7; i++) step(1, 32'h3000 + i, 0, 0, 0, 0, 0);
      step(1, 32'h3007, 1, 0, 0, 0, 0);
      chk("t6_pre_level", a_if.level, 7);
      step(1, 32'h99, 1, 1, 0, 0, 0);
      chk("t6_flush_level", a_if.level, 0);
      chk("t6_flush_valid", a_if.out_valid, 0);
      step(1, 32'h3C, 0, 0, 0, 0, 0);
      chk("t6_first_valid", a_if.out_valid, 1);
      chk("t6_first_data", a_if.out_data, 32'h3C);
      drain_a("t6_drained");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
